// File: rtl/fpga_robots_game_kc_tx_pkg.sv
// Shared constants and FSM state encoding for the keycode serial encoder.
// SYNC/GAP3 states exist only when FPGA_ROBOTS_KC_TX_SYNC_EN is defined.
package fpga_robots_game_kc_tx_pkg;

    localparam logic [3:0] KC_PFX_HI    = 4'h4;
    localparam logic [3:0] KC_PFX_LO    = 4'h5;
    localparam logic [7:0] KC_SYNC_BYTE = 8'h0a;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HI   = 3'd1,
        ST_GAP1 = 3'd2,
        ST_LO   = 3'd3,
`ifdef FPGA_ROBOTS_KC_TX_SYNC_EN
        ST_GAP2 = 3'd4,
        ST_SYNC = 3'd5,
        ST_GAP3 = 3'd6
`else
        ST_GAP2 = 3'd4
`endif
    } kc_state_t;

    function automatic logic [7:0] kc_byte(input logic [3:0] pfx, input logic [3:0] nib);
        return {pfx, nib};
    endfunction

endpackage

// File: rtl/fpga_robots_game_kc_fifo.sv
// Keycode FIFO: depth 2**FIFO_LOG2, show-ahead read data, count/full/empty from registers.
// Latency: pushed word visible at pop_dat the cycle after the push.
// Backpressure: push while full is ignored unless a pop happens in the same cycle.
module fpga_robots_game_kc_fifo #(
    parameter int FIFO_LOG2 = 3,
    parameter int W         = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic [W-1:0]         push_dat,
    input  logic                 pop,
    output logic [W-1:0]         pop_dat,
    output logic                 full,
    output logic                 empty,
    output logic [FIFO_LOG2:0]   cnt
);

    localparam int                   DEPTH    = 2 ** FIFO_LOG2;
    localparam logic [FIFO_LOG2:0]   CNT_FULL = (FIFO_LOG2 + 1)'(DEPTH);
    localparam logic [FIFO_LOG2:0]   CNT_ONE  = (FIFO_LOG2 + 1)'(1);
    localparam logic [FIFO_LOG2-1:0] PTR_ONE  = (FIFO_LOG2)'(1);

    logic [W-1:0]         mem [DEPTH];
    logic [FIFO_LOG2-1:0] wr_ptr;
    logic [FIFO_LOG2-1:0] rd_ptr;
    logic                 do_push;
    logic                 do_pop;

    assign full    = (cnt == CNT_FULL);
    assign empty   = (cnt == '0);
    assign do_pop  = pop && !empty;
    // A pop frees the slot in the same cycle, so a full FIFO can still take a push.
    assign do_push = push && (!full || do_pop);
    assign pop_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CNT_ONE;
                2'b01:   cnt <= cnt - CNT_ONE;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/fpga_robots_game_kc_tx.sv
// Keycode-to-serial encoder: each code becomes {4,hi} then {5,lo}; FPGA_ROBOTS_KC_TX_SYNC_EN appends 0x0a.
// Latency: kc_stb at cycle N gives stb at N+3 and N+5 with rdy high and the FIFO empty.
// Backpressure: ser_tx_rdy low stalls before each byte; codes arriving to a full FIFO are dropped (sticky ovf).
module fpga_robots_game_kc_tx
    import fpga_robots_game_kc_tx_pkg::*;
#(
    parameter int FIFO_LOG2 = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           kc_dat,
    input  logic                 kc_stb,
    output logic [7:0]           ser_tx_dat,
    output logic                 ser_tx_stb,
    input  logic                 ser_tx_rdy,
    output logic                 busy,
    output logic                 ovf,
    output logic [FIFO_LOG2:0]   fifo_cnt
);

    kc_state_t  state;
    kc_state_t  state_nxt;
    logic [7:0] hold;
    logic [7:0] hold_nxt;
    logic [7:0] dat_nxt;
    logic       stb_nxt;
    logic       busy_nxt;
    logic       pop;
    logic       push_ok;
    logic       full;
    logic       empty;
    logic [7:0] head;

    fpga_robots_game_kc_fifo #(
        .FIFO_LOG2 (FIFO_LOG2),
        .W         (8)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (kc_stb),
        .push_dat (kc_dat),
        .pop      (pop),
        .pop_dat  (head),
        .full     (full),
        .empty    (empty),
        .cnt      (fifo_cnt)
    );

    assign pop     = (state == ST_IDLE) && !empty;
    assign push_ok = kc_stb && (!full || pop);

    always_comb begin
        state_nxt = state;
        hold_nxt  = hold;
        dat_nxt   = ser_tx_dat;
        stb_nxt   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!empty) begin
                    hold_nxt  = head;
                    state_nxt = ST_HI;
                end
            end
            ST_HI: begin
                if (ser_tx_rdy) begin
                    dat_nxt   = kc_byte(KC_PFX_HI, hold[7:4]);
                    stb_nxt   = 1'b1;
                    state_nxt = ST_GAP1;
                end
            end
            // Dead cycle lets the transmitter drop rdy before we look at it again.
            ST_GAP1: state_nxt = ST_LO;
            ST_LO: begin
                if (ser_tx_rdy) begin
                    dat_nxt   = kc_byte(KC_PFX_LO, hold[3:0]);
                    stb_nxt   = 1'b1;
                    state_nxt = ST_GAP2;
                end
            end
`ifdef FPGA_ROBOTS_KC_TX_SYNC_EN
            ST_GAP2: state_nxt = ST_SYNC;
            ST_SYNC: begin
                if (ser_tx_rdy) begin
                    dat_nxt   = KC_SYNC_BYTE;
                    stb_nxt   = 1'b1;
                    state_nxt = ST_GAP3;
                end
            end
            ST_GAP3: state_nxt = ST_IDLE;
`else
            ST_GAP2: state_nxt = ST_IDLE;
`endif
            default: state_nxt = ST_IDLE;
        endcase
        // A pop always leaves IDLE, so a non-empty FIFO without a pop stays non-empty.
        busy_nxt = (state_nxt != ST_IDLE) || push_ok || !empty;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            hold       <= 8'h00;
            ser_tx_dat <= 8'h00;
            ser_tx_stb <= 1'b0;
            busy       <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            state      <= state_nxt;
            hold       <= hold_nxt;
            ser_tx_dat <= dat_nxt;
            ser_tx_stb <= stb_nxt;
            busy       <= busy_nxt;
            if (kc_stb && !push_ok) begin
                ovf <= 1'b1;
            end
        end
    end

endmodule
